dmem_atomic_ctrl: RTL and testbench

- Memory-side responder for the datapath's data-memory requests (MemRead, MemWrite, datomic) raised by the decode/control path.
- Sequences each request onto a single-port RAM with a variable-latency `ramstate` handshake, returns `dhit` and `dmemload`, and owns the LL/SC link register.
- Sits between datapath and memory controller, one instance per core. Snoop inputs from the other core's writes break the link.

---
 rtl/dmem_atomic_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_atomic_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_atomic_ctrl.sv
// Data-memory responder: sequences datapath loads/stores onto a single-port RAM and owns the
// LL/SC link register. Optional feature macro: LLSC_EN (link register and snoop handling).
module dmem_atomic_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              dmem_err,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRY_MAX);
  localparam logic [1:0] RamAccess = 2'b10;
  localparam logic [1:0] RamError  = 2'b11;
  localparam logic [DATA_W-1:0] ScOk = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StBusyRd, StBusyWr, StDone} state_e;

  state_e            state_q;
  logic [RetryW-1:0] retry_q;
  logic              link_hit;
  logic              busy;

  assign ramREN   = (state_q == StBusyRd);
  assign ramWEN   = (state_q == StBusyWr);
  assign busy     = ramREN | ramWEN;
  assign ramaddr  = busy ? dmemaddr : '0;
  assign ramstore = busy ? dmemstore : '0;

`ifdef LLSC_EN
  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:2] link_addr_q, link_addr_d;
  logic              unused_snoop_lo;

  assign unused_snoop_lo = ^snoop_addr[1:0];
  assign link_hit = link_valid_q && (link_addr_q == dmemaddr[ADDR_W-1:2]);

  // Lowest priority first so later assignments win; snoop is compared against the
  // post-LL address so a same-cycle snoop on the LL word leaves the link invalid.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (state_q == StBusyRd && ramstate == RamAccess && datomic) begin
      link_valid_d = 1'b1;
      link_addr_d  = dmemaddr[ADDR_W-1:2];
    end
    if (state_q == StBusyWr && ramstate == RamAccess &&
        link_addr_q == dmemaddr[ADDR_W-1:2]) begin
      link_valid_d = 1'b0;
    end
    if (snoop_valid && snoop_addr[ADDR_W-1:2] == link_addr_d) begin
      link_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  logic unused_snoop;

  assign unused_snoop = ^{snoop_valid, snoop_addr};
  // Without a link every SC proceeds to the RAM as a store.
  assign link_hit = 1'b1;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      retry_q  <= '0;
      dhit     <= 1'b0;
      dmemload <= '0;
      dmem_err <= 1'b0;
    end else begin
      dhit <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dmemWEN) begin
            if (datomic && !link_hit) begin
              state_q  <= StDone;
              dhit     <= 1'b1;
              dmemload <= '0;
            end else begin
              state_q <= StBusyWr;
            end
          end else if (dmemREN) begin
            state_q <= StBusyRd;
          end
        end
        StBusyRd, StBusyWr: begin
          if (ramstate == RamAccess) begin
            state_q <= StDone;
            dhit    <= 1'b1;
            retry_q <= '0;
            if (state_q == StBusyRd) begin
              dmemload <= ramload;
            end else if (datomic) begin
              dmemload <= ScOk;
            end
          end else if (ramstate == RamError) begin
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              state_q  <= StDone;
              dhit     <= 1'b1;
              dmemload <= '0;
              dmem_err <= 1'b1;
              retry_q  <= '0;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_atomic_ctrl.sv
// Self-checking bench for dmem_atomic_ctrl: table of request records with a RAM responder,
// a dmemload scoreboard, and hand-written reset sequences. Expectations follow LLSC_EN.
module tb_dmem_atomic_ctrl;

`ifdef LLSC_EN
  localparam bit Llsc = 1'b1;
`else
  localparam bit Llsc = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_ren, dmem_wen, dmem_atomic;
  logic [31:0] dmem_addr, dmem_store;
  logic        dhit, dmem_err, ram_ren, ram_wen;
  logic [31:0] dmem_load, ram_addr, ram_store, ram_load;
  logic [1:0]  ram_state;
  logic        snp_valid;
  logic [31:0] snp_addr;

  always #5 clk = ~clk;

  dmem_atomic_ctrl #(.ADDR_W(32), .DATA_W(32), .RETRY_MAX(3)) dut (
    .CLK(clk), .nRST(rst_n),
    .dmemREN(dmem_ren), .dmemWEN(dmem_wen), .datomic(dmem_atomic),
    .dmemaddr(dmem_addr), .dmemstore(dmem_store),
    .dhit(dhit), .dmemload(dmem_load), .dmem_err(dmem_err),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr), .ramstore(ram_store),
    .ramload(ram_load), .ramstate(ram_state),
    .snoop_valid(snp_valid), .snoop_addr(snp_addr)
  );

  typedef struct {
    logic        ren, wen, at;
    logic [31:0] addr, store, rdata;
    int          busy, errs;
    int          snp;       // 0 none, 1 one cycle before request, 2 in the ACCESS cycle
    logic [31:0] snp_addr;
    logic [31:0] exp_load;
    int          exp_lat, exp_rd, exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ren, wen, at, input logic [31:0] addr, store, rdata,
                              input int busy, errs, snp, input logic [31:0] sa,
                              input logic [31:0] el, input int lat, rd, wr, input logic er);
    vec_t v;
    v.ren = ren; v.wen = wen; v.at = at; v.addr = addr; v.store = store; v.rdata = rdata;
    v.busy = busy; v.errs = errs; v.snp = snp; v.snp_addr = sa;
    v.exp_load = el; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr; v.exp_err = er;
    return v;
  endfunction

  // SC expected to fail when the link is absent (LLSC build) or to act as a store otherwise.
  function automatic vec_t mk_sc_nolink(input logic [31:0] addr, store, input logic er);
    if (Llsc) return mk(0, 1, 1, addr, store, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, er);
    return mk(0, 1, 1, addr, store, 0, 0, 0, 0, 0, 32'h1, 2, 0, 1, er);
  endfunction

  function automatic vec_t mk_ll(input logic [31:0] addr, rdata, input logic er);
    return mk(1, 0, 1, addr, 0, rdata, 0, 0, 0, 0, rdata, 2, 1, 0, er);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int k = 0, lat = 0, rd_n = 0, wr_n = 0;
    bit done = 0;
    if (v.snp == 1) begin
      snp_valid = 1'b1; snp_addr = v.snp_addr;
      @(negedge clk);
      snp_valid = 1'b0;
    end
    dmem_ren = v.ren; dmem_wen = v.wen; dmem_atomic = v.at;
    dmem_addr = v.addr; dmem_store = v.store; ram_load = v.rdata; ram_state = 2'b00;
    sb_q.push_back(v.exp_load);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      snp_valid = 1'b0;
      if (ram_ren || ram_wen) begin
        if (k == 0) begin
          check($sformatf("v%0d_ramaddr", idx), ram_addr, v.addr);
          if (ram_wen) check($sformatf("v%0d_ramstore", idx), ram_store, v.store);
        end
        rd_n += int'(ram_ren);
        wr_n += int'(ram_wen);
        if (k < v.errs) ram_state = 2'b11;
        else if (k < v.errs + v.busy) ram_state = 2'b01;
        else begin
          ram_state = 2'b10;
          if (v.snp == 2) begin
            snp_valid = 1'b1; snp_addr = v.snp_addr;
          end
        end
        k++;
      end else begin
        ram_state = 2'b00;
      end
      if (dhit) begin
        done = 1;
        if (sb_q.size() > 0) check($sformatf("v%0d_dmemload", idx), dmem_load, sb_q.pop_front());
      end
    end
    if (!done) check($sformatf("v%0d_timeout_dhit", idx), 32'(dhit), 32'h1);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_ramREN_cycles", idx), 32'(rd_n), 32'(v.exp_rd));
    check($sformatf("v%0d_ramWEN_cycles", idx), 32'(wr_n), 32'(v.exp_wr));
    check($sformatf("v%0d_dmem_err", idx), 32'(dmem_err), 32'(v.exp_err));
    dmem_ren = 0; dmem_wen = 0; dmem_atomic = 0; ram_state = 2'b00; snp_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_dhit_single", idx), 32'(dhit), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dhit"}, 32'(dhit), 32'h0);
    check({tag, "_dmemload"}, dmem_load, 32'h0);
    check({tag, "_dmem_err"}, 32'(dmem_err), 32'h0);
    check({tag, "_ramREN"}, 32'(ram_ren), 32'h0);
    check({tag, "_ramWEN"}, 32'(ram_wen), 32'h0);
    check({tag, "_ramaddr"}, ram_addr, 32'h0);
    check({tag, "_ramstore"}, ram_store, 32'h0);
  endtask

  initial begin
    int dhits;
    rst_n = 1'b0;
    dmem_ren = 0; dmem_wen = 0; dmem_atomic = 0; dmem_addr = 0; dmem_store = 0;
    ram_load = 0; ram_state = 2'b00; snp_valid = 0; snp_addr = 0;

    // LW with 3 BUSY cycles, LL/SC pairs, snoop/local-store link breaks, retries and errors.
    vecs.push_back(mk(1, 0, 0, 32'h100, 0, 32'hDEADBEEF, 3, 0, 0, 0, 32'hDEADBEEF, 5, 4, 0, 0));
    vecs.push_back(mk_ll(32'h200, 32'h11111111, 0));
    vecs.push_back(mk(0, 1, 1, 32'h200, 32'h5, 0, 0, 0, 0, 0, 32'h1, 2, 0, 1, 0));
    vecs.push_back(mk_sc_nolink(32'h200, 32'h6, 0));
    vecs.push_back(mk_ll(32'h200, 32'h22222222, 0));
    begin
      vec_t v = mk_sc_nolink(32'h200, 32'h7, 0);
      v.snp = 1; v.snp_addr = 32'h202;
      vecs.push_back(v);
    end
    vecs.push_back(mk_ll(32'h200, 32'h33333333, 0));
    vecs.push_back(mk(0, 1, 0, 32'h200, 32'h8, 0, 0, 0, 0, 0, 32'h33333333, 2, 0, 1, 0));
    vecs.push_back(mk_sc_nolink(32'h200, 32'h9, 0));
    vecs.push_back(mk(1, 0, 1, 32'h300, 0, 32'h44444444, 1, 1, 0, 0, 32'h44444444, 4, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h300, 32'hA, 0, 2, 0, 0, 0, 32'h1, 4, 0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 32'h400, 0, 32'h55555555, 0, 0, 2, 32'h400,
                      32'h55555555, 2, 1, 0, 0));
    vecs.push_back(mk_sc_nolink(32'h400, 32'hB, 0));
    vecs.push_back(mk_ll(32'h500, 32'h66666666, 0));
    vecs.push_back(mk(0, 1, 1, 32'h500, 32'hC, 0, 0, 0, 2, 32'h500, 32'h1, 2, 0, 1, 0));
    vecs.push_back(mk_sc_nolink(32'h500, 32'hD, 0));
    vecs.push_back(mk(0, 1, 0, 32'h610, 32'hE, 0, 0, 3, 0, 0, Llsc ? 32'h0 : 32'h1, 5, 0, 4, 0));
    vecs.push_back(mk(0, 1, 0, 32'h620, 32'hF, 0, 0, 4, 0, 0, 32'h0, 5, 0, 4, 1));
    vecs.push_back(mk(1, 0, 0, 32'h104, 0, 32'hCAFEF00D, 0, 0, 0, 0, 32'hCAFEF00D, 2, 1, 0, 1));
    vecs.push_back(mk_sc_nolink(32'h700, 32'h10, 1));
    vecs.push_back(mk(1, 1, 0, 32'h800, 32'h11, 32'h99999999, 0, 0, 0, 0,
                      Llsc ? 32'h0 : 32'h1, 2, 0, 1, 1));
    vecs.push_back(mk_ll(32'h900, 32'h77777777, 1));

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while a load is waiting in BUSY: abandons it, clears link and sticky error.
    dmem_ren = 1; dmem_addr = 32'h104; ram_state = 2'b01;
    @(negedge clk);
    check("midrst_busy_ramREN", 32'(ram_ren), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    dmem_ren = 0; ram_state = 2'b00;
    rst_n = 1'b1;
    dhits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dhits += int'(dhit);
    end
    check("midrst_no_dhit", 32'(dhits), 32'h0);
    run_vec(mk_sc_nolink(32'h900, 32'h12, 0), 100);

    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
